if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS CPU. Holds the program counter, drives the instruction-memory address, and registers the fetched word with its PC+4. Applies stall, flush and branch/jump redirects. Splits the registered instruction into decode fields; the 16-bit immediate goes directly to the decode-stage sign-extension unit.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; one clock, asynchronous, active-low.
- stall_i  in  1  hazard-unit hold: PC and IF/ID register keep their values.
- flush_i  in  1  squash the IF/ID contents, replacing them with a bubble.
- redirect_i  in  1  taken branch or jump resolved downstream.
- target_i  in  32  redirect destination.
- pc_o  out  32  current PC; combinationally drives the instruction-memory address.
- instr_i  in  32  instruction-memory read data for pc_o (combinational memory).
- instr_o  out  32  registered instruction (IF/ID).
- pc_plus4_o  out  32  registered PC+4 of instr_o.
- valid_o  out  1  instr_o is a real fetched instruction, not a bubble.
- opcode_o  out  6  instr_o[31:26].
- rs_o  out  5  instr_o[25:21].
- rt_o  out  5  instr_o[20:16].
- rd_o  out  5  instr_o[15:11].
- funct_o  out  6  instr_o[5:0].
- imm16_o  out  16  instr_o[15:0]; feeds sign extension.
- misalign_o  out  1  sticky flag, set when a redirect target has bits [1:0] ≠ 0.

## Operation
- **State:** PC register, IF/ID register {instr, pc_plus4, valid}, misalign flag.
- **Decode fields** are pure slices of instr_o; they are never registered separately.
- **PC+4 adder:** 32-bit and modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- **Per-edge priority (highest first):**
  - reset;
  - redirect_i;
  - stall_i;
  - normal.
- **redirect_i=1:**
  - PC ← {target_i[31:2], 2'b00};
  - IF/ID ← {NOP_WORD, 0, valid=0};
  - stall_i is ignored. A redirect overrides a simultaneous load-use stall, because the stalled instruction is on the wrong path.
- **flush_i=1 (no redirect):**
  - IF/ID ← bubble;
  - PC ← PC+4 if stall_i=0, otherwise PC holds.
- **stall_i=1 (no redirect, no flush):** PC and IF/ID hold; the memory address stays on the current PC.
- **Normal:** PC ← PC+4; IF/ID ← {instr_i, PC+4, 1}.
- **misalign_o:**
  - Set on any edge where redirect_i=1 and target_i[1:0]≠0.
  - Cleared only by reset.
  - The PC itself is always forced aligned.

## Timing
- **Reset (asynchronous assert, active-low):**
  - pc_o=RESET_PC, instr_o=NOP_WORD, pc_plus4_o=0, valid_o=0, misalign_o=0.
  - All decode fields follow NOP_WORD.
- **Reset release:** the first rising edge with rst_i=1 fetches from RESET_PC. instr_o holds mem[RESET_PC] and valid_o=1 after that edge.
- **Latency:** 1 cycle from pc_o presentation to instr_o.
- **Sustained throughput:** one instruction per cycle when stall_i=0.
- **Redirect penalty:**
  - The edge that samples redirect_i=1 loads the target and inserts one bubble.
  - The target instruction appears on instr_o one edge later.
- **Stall:** outputs are unchanged for every cycle that stall_i is high; fetch resumes on the first edge after stall_i falls.
- **Reset mid-stream:** reset discards all in-flight state immediately and does not wait for a clock.
- **Inputs:** all control inputs are sampled only at the rising edge.
- **Outputs:**
  - pc_o, instr_o, pc_plus4_o, valid_o and misalign_o change only at the edge or on reset.
  - The decode fields change combinationally with instr_o.

## Test plan
- **Reset and sequential fetch:**
  - Stimulus: memory holds words at 0x0, 0x4, 0x8; release reset.
  - Required response: across 3 edges pc_o = 0x4, 0x8, 0xC; instr_o follows mem[0], mem[4], mem[8]; pc_plus4_o = 0x4, 0x8, 0xC; valid_o=1.
- **Decode split:**
  - Stimulus: mem[0]=32'h2128_FFFC (addi $8,$9,-4).
  - Required response: opcode_o=6'h08, rs_o=9, rt_o=8, imm16_o=16'hFFFC.
- **Stall for 2 cycles at PC=0x8:**
  - Required response: pc_o, instr_o and valid_o are unchanged for both edges; the next edge gives pc_o=0xC.
- **Redirect together with stall:**
  - Stimulus: redirect_i=1, stall_i=1, target_i=0x40.
  - Required response: after the edge pc_o=0x40, instr_o=NOP_WORD, valid_o=0; the next edge gives instr_o=mem[0x40], pc_plus4_o=0x44.
- **Misaligned target and flush:**
  - Stimulus: target_i=0x42 with a redirect.
  - Required response: pc_o=0x40 and misalign_o=1, staying 1 afterwards.
  - Stimulus: then flush_i=1 alone.
  - Required response: valid_o=0 and the PC advances by 4.
- **Reset mid-stream and wrap-around:**
  - Stimulus: assert rst_i low mid-cycle.
  - Required response: pc_o=RESET_PC and valid_o=0 immediately, with no clock edge.
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Required response: the next edge gives pc_o=0x0 and pc_plus4_o=0x0.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the pipelined MIPS CPU.
// Holds the PC, presents it to instruction memory, and registers the fetched word, its PC+4 and a valid bit.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic [5:0]  opcode_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [5:0]  funct_o,
    output logic [15:0] imm16_o,
    output logic        misalign_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_inc;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_q;
    logic [31:0] pc_plus4_d;
    logic        valid_q;
    logic        valid_d;
    logic        misalign_q;
    logic        misalign_d;

    // Modulo-2^32 increment: the top word wraps to address zero silently.
    assign pc_inc = pc_q + 32'd4;

    // A redirect beats a stall because the stalled instruction is on the wrong path.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;

        if (redirect_i) begin
            pc_d       = {target_i[31:2], 2'b00};
            instr_d    = NOP_WORD;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
            if (target_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (flush_i) begin
            instr_d    = NOP_WORD;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
            if (!stall_i) begin
                pc_d = pc_inc;
            end
        end else if (!stall_i) begin
            pc_d       = pc_inc;
            instr_d    = instr_i;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_WORD;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;
    assign misalign_o = misalign_q;

    // Decode fields are plain slices so decode sees them in the same cycle as instr_o.
    assign opcode_o = instr_q[31:26];
    assign rs_o     = instr_q[25:21];
    assign rt_o     = instr_q[20:16];
    assign rd_o     = instr_q[15:11];
    assign funct_o  = instr_q[5:0];
    assign imm16_o  = instr_q[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized control traffic
// checked against a behavioural model of the fetch stage.
module tb_if_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] target_i;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic [5:0]  opcode_o;
    logic [4:0]  rs_o;
    logic [4:0]  rt_o;
    logic [4:0]  rd_o;
    logic [5:0]  funct_o;
    logic [15:0] imm16_o;
    logic        misalign_o;

    int vectors = 0;
    int miscompares = 0;

    // 64-word instruction memory, aliased across the address space by pc[7:2].
    logic [31:0] mem [64];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic        m_valid;
    logic        m_mis;

    if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .redirect_i(redirect_i), .target_i(target_i), .pc_o(pc_o), .instr_i(instr_i),
        .instr_o(instr_o), .pc_plus4_o(pc_plus4_o), .valid_o(valid_o),
        .opcode_o(opcode_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .funct_o(funct_o),
        .imm16_o(imm16_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb instr_i = mem[pc_o[7:2]];

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    endtask

    // Applies one set of controls across one rising edge and advances the model.
    task automatic drive_edge(input logic st, input logic fl, input logic rd, input logic [31:0] tg);
        stall_i = st; flush_i = fl; redirect_i = rd; target_i = tg;
        @(posedge clk_i);
        if (rd) begin
            if (tg % 4 != 0) m_mis = 1'b1;
            m_pc = tg - (tg % 4);
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        end else if (fl) begin
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
            if (!st) m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_instr = mem[(m_pc / 4) % 64];
            m_pp4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        #1;
        stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; target_i = 32'h0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; target_i = 32'h0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; target_i = 32'h0;
        model_reset();
        #1;
        vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0); end
        vectors++; if (instr_o !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected %h", instr_o, 32'h0); end
        vectors++; if (pc_plus4_o !== 32'h0) begin miscompares++; $display("FAIL reset_pp4: got %h expected %h", pc_plus4_o, 32'h0); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL reset_misalign: got %b expected 0", misalign_o); end
        vectors++; if ({opcode_o, rs_o, rt_o, imm16_o} !== 32'h0) begin miscompares++; $display("FAIL reset_fields: got %h expected 0", {opcode_o, rs_o, rt_o, imm16_o}); end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(4 * (k + 1));
            drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
            vectors++; if (pc_o !== exp_pc) begin miscompares++; $display("FAIL seq_pc%0d: got %h expected %h", k, pc_o, exp_pc); end
            vectors++; if (instr_o !== mem[k]) begin miscompares++; $display("FAIL seq_instr%0d: got %h expected %h", k, instr_o, mem[k]); end
            vectors++; if (pc_plus4_o !== exp_pc) begin miscompares++; $display("FAIL seq_pp4%0d: got %h expected %h", k, pc_plus4_o, exp_pc); end
            vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL seq_valid%0d: got %b expected 1", k, valid_o); end
        end
    endtask

    task automatic test_decode();
        do_reset();
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++; if (opcode_o !== 6'h08) begin miscompares++; $display("FAIL dec_opcode: got %h expected 08", opcode_o); end
        vectors++; if (rs_o !== 5'd9) begin miscompares++; $display("FAIL dec_rs: got %0d expected 9", rs_o); end
        vectors++; if (rt_o !== 5'd8) begin miscompares++; $display("FAIL dec_rt: got %0d expected 8", rt_o); end
        vectors++; if (imm16_o !== 16'hFFFC) begin miscompares++; $display("FAIL dec_imm: got %h expected fffc", imm16_o); end
        vectors++; if (rd_o !== 5'h1F) begin miscompares++; $display("FAIL dec_rd: got %h expected 1f", rd_o); end
        vectors++; if (funct_o !== 6'h3C) begin miscompares++; $display("FAIL dec_funct: got %h expected 3c", funct_o); end
    endtask

    task automatic test_stall();
        do_reset();
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
            vectors++; if (pc_o !== 32'h8) begin miscompares++; $display("FAIL stall_pc%0d: got %h expected 8", k, pc_o); end
            vectors++; if (instr_o !== mem[1]) begin miscompares++; $display("FAIL stall_instr%0d: got %h expected %h", k, instr_o, mem[1]); end
            vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL stall_valid%0d: got %b expected 1", k, valid_o); end
        end
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++; if (pc_o !== 32'hC) begin miscompares++; $display("FAIL stall_resume_pc: got %h expected c", pc_o); end
        vectors++; if (instr_o !== mem[2]) begin miscompares++; $display("FAIL stall_resume_instr: got %h expected %h", instr_o, mem[2]); end
    endtask

    task automatic test_redirect_stall();
        drive_edge(1'b1, 1'b0, 1'b1, 32'h40);
        vectors++; if (pc_o !== 32'h40) begin miscompares++; $display("FAIL redir_pc: got %h expected 40", pc_o); end
        vectors++; if (instr_o !== 32'h0) begin miscompares++; $display("FAIL redir_instr: got %h expected 0", instr_o); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL redir_valid: got %b expected 0", valid_o); end
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++; if (instr_o !== mem[16]) begin miscompares++; $display("FAIL redir_tgt_instr: got %h expected %h", instr_o, mem[16]); end
        vectors++; if (pc_plus4_o !== 32'h44) begin miscompares++; $display("FAIL redir_tgt_pp4: got %h expected 44", pc_plus4_o); end
        vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL redir_tgt_valid: got %b expected 1", valid_o); end
    endtask

    task automatic test_misalign_flush();
        drive_edge(1'b0, 1'b0, 1'b1, 32'h42);
        vectors++; if (pc_o !== 32'h40) begin miscompares++; $display("FAIL mis_pc: got %h expected 40", pc_o); end
        vectors++; if (misalign_o !== 1'b1) begin miscompares++; $display("FAIL mis_flag: got %b expected 1", misalign_o); end
        drive_edge(1'b0, 1'b1, 1'b0, 32'h0);
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b expected 0", valid_o); end
        vectors++; if (pc_o !== 32'h44) begin miscompares++; $display("FAIL flush_pc: got %h expected 44", pc_o); end
        vectors++; if (misalign_o !== 1'b1) begin miscompares++; $display("FAIL mis_sticky: got %b expected 1", misalign_o); end
        drive_edge(1'b1, 1'b1, 1'b0, 32'h0);
        vectors++; if (pc_o !== 32'h44) begin miscompares++; $display("FAIL flush_stall_pc: got %h expected 44", pc_o); end
        vectors++; if (instr_o !== 32'h0) begin miscompares++; $display("FAIL flush_stall_instr: got %h expected 0", instr_o); end
    endtask

    task automatic test_reset_midstream();
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL mid_reset_pc: got %h expected 0", pc_o); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b expected 0", valid_o); end
        vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL mid_reset_mis: got %b expected 0", misalign_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        drive_edge(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        vectors++; if (pc_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_redir_pc: got %h expected fffffffc", pc_o); end
        drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h expected 0", pc_o); end
        vectors++; if (pc_plus4_o !== 32'h0) begin miscompares++; $display("FAIL wrap_pp4: got %h expected 0", pc_plus4_o); end
        vectors++; if (instr_o !== mem[63]) begin miscompares++; $display("FAIL wrap_instr: got %h expected %h", instr_o, mem[63]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic st, fl, rd;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            rd = ($urandom_range(0, 9) == 0);
            drive_edge(st, fl, rd, $urandom);
            vectors++;
            if (pc_o !== m_pc || instr_o !== m_instr || pc_plus4_o !== m_pp4 || valid_o !== m_valid ||
                misalign_o !== m_mis || opcode_o !== m_instr[31:26] || rs_o !== m_instr[25:21] ||
                rt_o !== m_instr[20:16] || rd_o !== m_instr[15:11] || funct_o !== m_instr[5:0] ||
                imm16_o !== m_instr[15:0]) begin
                miscompares++;
                $display("FAIL rand_%0d: got pc=%h ins=%h pp4=%h v=%b mis=%b expected pc=%h ins=%h pp4=%h v=%b mis=%b",
                         n, pc_o, instr_o, pc_plus4_o, valid_o, misalign_o, m_pc, m_instr, m_pp4, m_valid, m_mis);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h2128_FFFC;
        test_reset();
        test_sequential();
        test_decode();
        test_stall();
        test_redirect_stall();
        test_misalign_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
